// File: rtl/clk_monitor_pkg.sv
// Shared types and default sizing for the clock monitor.
// Counter width and stuck timeout defaults live here so the top and benches agree.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/clk_monitor_edge_sync.sv
// Two-flop synchronizer plus a history flop for one asynchronous clock input.
// Outputs the synchronized level and a single-cycle rising-edge strobe.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: flops take non-blocking assignments so each stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;

endmodule

// File: rtl/clk_monitor.sv
// Clock monitor: measures period, high time and ref-to-mon phase of an
// asynchronous clock in clk cycles, and flags a clock that stops toggling.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_in,
  input  logic             ref_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] phase,
  output logic             meas_valid,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic mon_level;
  logic mon_rise;
  logic ref_level_unused;
  logic ref_rise;

  edge_sync u_mon_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (mon_in),
    .level (mon_level),
    .rise  (mon_rise)
  );

  edge_sync u_ref_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ref_in),
    .level (ref_level_unused),
    .rise  (ref_rise)
  );

  mon_state_t       state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] ph_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] ph_next;

  // Phase counter value after this edge; a coincident ref rise reads as zero.
  assign ph_next = ref_rise ? '0 : sat_inc(ph_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      ph_cnt     <= '0;
      to_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      phase      <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
        ph_cnt  <= '0;
        to_cnt  <= '0;
        stuck   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
            ph_cnt  <= '0;
            to_cnt  <= '0;
          end
          ARM, MEAS: begin
            ph_cnt <= ph_next;
            if (mon_rise) begin
              // Only a rise that closes a started period produces a result.
              if (state == MEAS) begin
                period     <= per_cnt;
                high_time  <= hi_cnt;
                phase      <= ph_next;
                meas_valid <= 1'b1;
              end
              state   <= MEAS;
              per_cnt <= CNT_ONE;
              hi_cnt  <= CNT_ONE;
              to_cnt  <= '0;
              stuck   <= 1'b0;
            end else if (to_cnt == TO_LAST) begin
              state   <= ARM;
              stuck   <= 1'b1;
              to_cnt  <= '0;
              per_cnt <= '0;
              hi_cnt  <= '0;
            end else begin
              to_cnt <= to_cnt + CNT_ONE;
              if (state == MEAS) begin
                per_cnt <= sat_inc(per_cnt);
                if (mon_level) hi_cnt <= sat_inc(hi_cnt);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Randomized scoreboard bench for clk_monitor: an event-level reference model
// predicts each measurement and the stuck flag from input sample history.
module tb_clk_monitor;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
  localparam int MAXV    = (1 << CNT_W) - 1;

  typedef struct {
    int edge_no;
    int per;
    int hi;
    int ph;
  } meas_t;

  logic clk = 1'b0;
  logic rst, enable, mon_in, ref_in, mon2;
  logic [CNT_W-1:0] period, high_time, phase;
  logic meas_valid, stuck;
  logic [7:0] period2, high_time2, phase2;
  logic meas_valid2, stuck2;

  always #5 clk = ~clk;

  clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mon_in     (mon_in),
    .ref_in     (ref_in),
    .period     (period),
    .high_time  (high_time),
    .phase      (phase),
    .meas_valid (meas_valid),
    .stuck      (stuck)
  );

  // Narrow instance with the largest legal timeout for the no-wrap case.
  clk_monitor #(.CNT_W(8), .TIMEOUT(255)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mon_in     (mon2),
    .ref_in     (1'b0),
    .period     (period2),
    .high_time  (high_time2),
    .phase      (phase2),
    .meas_valid (meas_valid2),
    .stuck      (stuck2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;
  int n_valid  = 0;
  int n_valid2 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e - 1);
    end
  endtask

  // ---------------- reference model ----------------
  bit    mh[$];
  bit    rh[$];
  meas_t sbq[$];
  bit    active = 0, have_rise = 0, exp_stuck = 0;
  bit    ml, mr, rr;
  int    t_rise = 0, t0 = 0, ph_ref = 0, hi_sum = 0;
  int    hold_p = 0, hold_h = 0, hold_ph = 0;
  meas_t item;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Synced level seen at edge k is the input sampled two edges earlier;
  // reset edges wipe the synchronizer, recorded here as zero samples.
  function automatic bit mlev(input int k);
    return (k >= 2) ? mh[k-2] : 1'b0;
  endfunction

  function automatic bit rlev(input int k);
    return (k >= 2) ? rh[k-2] : 1'b0;
  endfunction

  always @(posedge clk) begin
    mh.push_back(rst ? 1'b0 : mon_in);
    rh.push_back(rst ? 1'b0 : ref_in);
    if (rst && e >= 1) begin
      mh[e-1] = 1'b0;
      rh[e-1] = 1'b0;
    end
    ml = mlev(e);
    mr = ml && !mlev(e - 1);
    rr = rlev(e) && !rlev(e - 1);
    if (rst) begin
      active = 0; have_rise = 0; exp_stuck = 0;
      hold_p = 0; hold_h = 0; hold_ph = 0;
    end else if (!enable) begin
      active = 0; have_rise = 0; exp_stuck = 0;
    end else if (!active) begin
      active = 1; have_rise = 0; t0 = e; ph_ref = e;
    end else begin
      if (rr) ph_ref = e;
      if (mr) begin
        if (have_rise) begin
          hi_sum = 0;
          for (int k = t_rise; k < e; k++) hi_sum += int'(mlev(k));
          item.edge_no = e;
          item.per     = sat(e - t_rise);
          item.hi      = sat(hi_sum);
          item.ph      = sat(e - ph_ref);
          sbq.push_back(item);
          hold_p = item.per; hold_h = item.hi; hold_ph = item.ph;
        end
        have_rise = 1; t_rise = e; t0 = e; exp_stuck = 0;
      end else if (e - t0 == TIMEOUT) begin
        exp_stuck = 1; have_rise = 0; t0 = e;
      end
    end
    e++;
  end

  // ---------------- monitor ----------------
  meas_t got;

  always @(negedge clk) begin
    if (meas_valid2 === 1'b1) n_valid2++;
    if (meas_valid === 1'b1) begin
      n_valid++;
      if (sbq.size() == 0) begin
        check("meas_valid_unexpected", meas_valid, 0);
      end else begin
        got = sbq.pop_front();
        check("valid_edge", e - 1, got.edge_no);
        check("period", period, got.per);
        check("high_time", high_time, got.hi);
        check("phase", phase, got.ph);
      end
    end else begin
      check("hold_period", period, hold_p);
      check("hold_high_time", high_time, hold_h);
      check("hold_phase", phase, hold_ph);
    end
    check("stuck", stuck, exp_stuck);
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit m, input bit r);
    @(negedge clk);
    mon_in = m;
    ref_in = r;
  endtask

  task automatic wave(input int n, input int mper, input int mhi,
                      input int rper, input int rdel, input int start);
    for (int i = start; i < start + n; i++)
      step((i % mper) < mhi, (rper > 0) && (((i + rdel) % rper) < rper / 2));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int v0;

  initial begin
    rst = 1'b1; enable = 1'b0; mon_in = 1'b0; ref_in = 1'b0; mon2 = 1'b0;
    repeat (3) step(0, 0);
    check("reset_period", period, 0);
    check("reset_high_time", high_time, 0);
    check("reset_phase", phase, 0);
    check("reset_meas_valid", meas_valid, 0);
    check("reset_stuck", stuck, 0);
    rst = 1'b0;
    enable = 1'b1;

    // Steady 10-cycle clock, high for 4.
    wave(20, 10, 4, 0, 0, 0);
    v0 = n_valid;
    wave(50, 10, 4, 0, 0, 20);
    check("steady_valid_count", n_valid - v0, 5);
    check("steady_period", period, 10);
    check("steady_high_time", high_time, 4);

    // Phase against a same-period reference.
    wave(80, 20, 10, 20, 3, 0);
    check("phase_delay3", phase, 3);
    wave(80, 20, 10, 20, 0, 0);
    check("phase_delay0", phase, 0);

    // One rise then a long low stretch.
    for (int j = 0; j < 204; j++) begin
      step(j < 4, 0);
      if (j == 10) v0 = n_valid;
      if (j == 102) check("stuck_before_timeout", stuck, 0);
      if (j == 103) check("stuck_at_timeout", stuck, 1);
    end
    check("stuck_no_valid", n_valid - v0, 0);
    for (int k = 0; k < 6; k++) begin
      step(k < 4, 0);
      if (k == 2) check("stuck_held_until_rise", stuck, 1);
      if (k == 3) check("stuck_cleared_by_rise", stuck, 0);
    end

    // Enable dropped part way into a period.
    wave(40, 10, 4, 0, 0, 0);
    wave(5, 10, 4, 0, 0, 0);
    v0 = n_valid;
    enable = 1'b0;
    wave(10, 10, 4, 0, 0, 5);
    enable = 1'b1;
    wave(15, 12, 5, 0, 0, 0);
    check("disable_no_valid", n_valid - v0, 0);
    check("disable_hold_period", period, 10);
    check("disable_hold_high_time", high_time, 4);
    wave(21, 12, 5, 0, 0, 15);
    check("reenable_period", period, 12);
    check("reenable_high_time", high_time, 5);

    // Reset pulse mid-measurement.
    wave(25, 10, 4, 0, 0, 0);
    rst = 1'b1;
    wave(1, 10, 4, 0, 0, 25);
    check("rst_pulse_period", period, 0);
    check("rst_pulse_high_time", high_time, 0);
    check("rst_pulse_phase", phase, 0);
    check("rst_pulse_meas_valid", meas_valid, 0);
    check("rst_pulse_stuck", stuck, 0);
    rst = 1'b0;
    v0 = n_valid;
    wave(8, 10, 4, 0, 0, 26);
    check("rst_no_early_valid", n_valid - v0, 0);
    wave(30, 10, 4, 0, 0, 34);
    check("rst_recovered_period", period, 10);

    // Randomized segments with enable drops, resets and long gaps.
    for (int s = 0; s < 60; s++) begin
      int mper, mhi, rper, rdel, n, cut;
      mper = (($urandom % 8) == 0) ? $urandom_range(120, 180) : $urandom_range(3, 30);
      mhi  = $urandom_range(1, mper - 1);
      rper = (($urandom % 3) == 0) ? 0 : $urandom_range(4, 40);
      rdel = (rper > 0) ? $urandom_range(0, rper - 1) : 0;
      n    = (mper > 100) ? $urandom_range(200, 400) : $urandom_range(20, 120);
      if (($urandom % 6) == 0) begin
        cut = $urandom_range(1, n - 1);
        wave(cut, mper, mhi, rper, rdel, 0);
        enable = 1'b0;
        wave($urandom_range(1, 15), mper, mhi, rper, rdel, cut);
        enable = 1'b1;
        wave(n - cut, mper, mhi, rper, rdel, cut);
      end else begin
        wave(n, mper, mhi, rper, rdel, 0);
      end
      if (($urandom % 10) == 0) begin
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
      end
    end

    // Long mon period on the narrow instance: stuck must fire, no result.
    enable = 1'b1;
    repeat (300) step(0, 0);
    for (int j = 0; j < 800; j++) begin
      step(0, 0);
      if (j == 2)   check("w8_stuck_before_rise", stuck2, 1);
      if (j == 3)   check("w8_stuck_cleared", stuck2, 0);
      if (j == 257) check("w8_stuck_before_timeout", stuck2, 0);
      if (j == 258) check("w8_stuck_at_timeout", stuck2, 1);
      if (j == 271) check("w8_stuck_cleared_again", stuck2, 0);
      mon2 = (j % 266) < 4;
    end
    check("w8_no_valid", n_valid2, 0);
    check("w8_period", period2, 0);
    check("w8_high_time", high_time2, 0);
    check("w8_phase", phase2, 0);

    repeat (5) step(0, 0);
    check("pending_meas", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of all measurement counters and outputs.
REQ-002 Parameter TIMEOUT, default 65535, clk cycles without a mon_in rise before declaring stuck; SHALL satisfy 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 enable  input  1  measurement enable; low forces IDLE.
REQ-006 mon_in  input  1  asynchronous clock under test.
REQ-007 ref_in  input  1  asynchronous phase reference clock.
REQ-008 period  output  CNT_W  clk cycles between consecutive mon_in rises.
REQ-009 high_time  output  CNT_W  sampled-high clk cycles within that period.
REQ-010 phase  output  CNT_W  clk cycles from last ref_in rise to the mon_in rise.
REQ-011 meas_valid  output  1  one-cycle pulse when period/high_time/phase update.
REQ-012 stuck  output  1  mon_in has shown no rise for TIMEOUT cycles.

Function
REQ-013 mon_in and ref_in SHALL each pass a 2-flop synchronizer plus one history flop; rise = synced high and history low; input-to-rise latency 3 clk cycles.
REQ-014 FSM states SHALL be IDLE, ARM, MEAS.
REQ-015 IDLE -> ARM when enable=1; any state -> IDLE when enable=0.
REQ-016 ARM: on mon rise -> MEAS, per_cnt<=1, hi_cnt<=1, stuck<=0; no meas_valid.
REQ-017 MEAS: per_cnt increments every cycle; hi_cnt increments each cycle synced mon is high; both saturate at 2^CNT_W-1.
REQ-018 MEAS on mon rise: period<=per_cnt, high_time<=hi_cnt, phase<=ph_cnt, meas_valid=1 next cycle only, then per_cnt<=1, hi_cnt<=1.
REQ-019 ph_cnt SHALL clear to 0 on ref rise and otherwise increment each cycle, saturating; runs in ARM and MEAS, cleared in IDLE.
REQ-020 ref rise and mon rise in the same cycle SHALL latch phase=0.
REQ-021 In ARM or MEAS, TIMEOUT consecutive cycles without mon rise SHALL set stuck=1 and move to ARM without meas_valid; stuck clears on next mon rise.
REQ-022 IDLE: internal counters cleared, period/high_time/phase hold last values, meas_valid=0, stuck=0.
REQ-023 Dropping enable mid-measurement SHALL discard the partial period (no meas_valid).

Reset
REQ-024 rst=1 SHALL force state IDLE, all synchronizer/history flops 0, all counters 0, period=high_time=phase=0, meas_valid=0, stuck=0, within one clk edge, overriding enable.
REQ-025 rst asserted mid-MEAS SHALL discard the partial period; after release first meas_valid needs enable high and two mon rises.

Structure
REQ-026 Package clk_monitor_pkg SHALL hold the FSM state typedef and default CNT_W/TIMEOUT constants.
REQ-027 One sub-module edge_sync (2-flop synchronizer + history flop, outputs level and rise), instantiated for mon_in and ref_in.

Verification
REQ-028 enable=1, mon_in period 10 clk, high 4 -> from second rise on, meas_valid every 10 cycles, period=10, high_time=4.
REQ-029 ref_in period 20, mon_in same period delayed 3 clk -> phase=3; delay 0 -> phase=0.
REQ-030 TIMEOUT=100, mon_in held low 200 cycles after one rise -> stuck=1 exactly 100 cycles after last rise, no meas_valid; next rise clears stuck.
REQ-031 enable dropped 5 cycles into a period, re-raised -> no meas_valid for the partial period; outputs hold prior values; first valid after two new rises.
REQ-032 rst pulsed 1 cycle mid-MEAS -> all outputs 0 next cycle, state IDLE, behaviour per REQ-025.
REQ-033 mon_in period 2^CNT_W+10 with TIMEOUT max -> stuck asserts, period never wraps to small value.
